fpalu_issue_arb: RTL and testbench

- Shares the single pipelined FP ALU (29-bit internal format: sign, 6-bit exponent, 22-bit mantissa) between two requesters. Requester 0 is the MUL16i stream; requester 1 is the ACC/ADD29i stream.
- Arbitrates per cycle and registers the winning operation onto the ALU input bus.
- Tracks each in-flight op through a LAT-deep tag pipe and routes the ALU result back to the originating requester with its tag.
- Enforces serialization for the normalizing add (opcode 2'b00). Drives the ALU clock enable used for gating.

---
 rtl/fpalu_issue_arb_if.sv | 54 +++++
 rtl/fpalu_issue_arb.sv | 136 +++++++++++++
 tb/tb_fpalu_issue_arb.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpalu_issue_arb_if.sv
`default_nettype none
// ============================================================================
// Module : fpalu_issue_arb_if
// Request, ALU and response bundle for the shared FP ALU issue arbiter.
// Rev    : 1.0
// ============================================================================
interface fpalu_issue_arb_if #(
    parameter int TW = 4
);
    logic          req0_valid;
    logic          req0_ready;
    logic [1:0]    req0_opcode;
    logic [28:0]   req0_a;
    logic [28:0]   req0_b;
    logic [TW-1:0] req0_tag;

    logic          req1_valid;
    logic          req1_ready;
    logic [1:0]    req1_opcode;
    logic [28:0]   req1_a;
    logic [28:0]   req1_b;
    logic [TW-1:0] req1_tag;

    logic          alu_en;
    logic [1:0]    alu_opcode;
    logic [28:0]   alu_a;
    logic [28:0]   alu_b;
    logic [28:0]   alu_y;

    logic          rsp0_valid;
    logic          rsp1_valid;
    logic [TW-1:0] rsp_tag;
    logic [28:0]   rsp_data;
    logic          busy;

    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b, req0_tag,
        input  req1_valid, req1_opcode, req1_a, req1_b, req1_tag,
        input  alu_y,
        output req0_ready, req1_ready,
        output alu_en, alu_opcode, alu_a, alu_b,
        output rsp0_valid, rsp1_valid, rsp_tag, rsp_data, busy
    );

    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b, req0_tag,
        output req1_valid, req1_opcode, req1_a, req1_b, req1_tag,
        output alu_y,
        input  req0_ready, req1_ready,
        input  alu_en, alu_opcode, alu_a, alu_b,
        input  rsp0_valid, rsp1_valid, rsp_tag, rsp_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/fpalu_issue_arb.sv
`default_nettype none
// ============================================================================
// Module : fpalu_issue_arb
// Round-robin issue of two requesters onto one pipelined FP ALU, tag return.
// Rev    : 1.0
// ============================================================================
module fpalu_issue_arb #(
    parameter int LAT = 5,
    parameter int TW  = 4
) (
    input wire               clk2,
    input wire               rst_n,
    input wire               clr,
    fpalu_issue_arb_if.slave bus
);
    localparam logic [1:0] c_OP_NORM = 2'b00;
    localparam logic [1:0] c_OP_RST  = 2'b11;

    logic           last_q,    last_d;
    logic           alu_en_q,  alu_en_d;
    logic [1:0]     alu_op_q,  alu_op_d;
    logic [28:0]    alu_a_q,   alu_a_d;
    logic [28:0]    alu_b_q,   alu_b_d;
    logic [LAT-1:0] pv_q,      pv_d;
    logic [LAT-1:0] pid_q,     pid_d;
    logic [LAT-1:0] pn_q,      pn_d;
    logic [TW-1:0]  ptag_q [LAT];
    logic [TW-1:0]  ptag_d [LAT];
    logic           rsp0_q,    rsp0_d;
    logic           rsp1_q,    rsp1_d;
    logic           rspn_q,    rspn_d;
    logic [TW-1:0]  rsp_tag_q, rsp_tag_d;

    logic w_busy, w_norm_busy;
    logic w_elig0, w_elig1, w_gnt0, w_gnt1, w_xfer;

    // The response register counts as the last pipe stage, so a normalize
    // op blocks everything until its response cycle has gone by.
    assign w_busy      = alu_en_q | (|pv_q) | rsp0_q | rsp1_q;
    assign w_norm_busy = (|(pv_q & pn_q)) | rspn_q;

    always_comb begin
        w_elig0 = bus.req0_valid & ~clr &
                  ((bus.req0_opcode == c_OP_NORM) ? ~w_busy : ~w_norm_busy);
        w_elig1 = bus.req1_valid & ~clr &
                  ((bus.req1_opcode == c_OP_NORM) ? ~w_busy : ~w_norm_busy);
        w_gnt0  = w_elig0 & (~w_elig1 | last_q);
        w_gnt1  = w_elig1 & (~w_elig0 | ~last_q);
        w_xfer  = w_gnt0 | w_gnt1;
    end

    always_comb begin
        last_d   = last_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_en_d = w_xfer;
        pv_d     = '0;
        pid_d    = '0;
        pn_d     = '0;
        for (int i = 0; i < LAT; i++) ptag_d[i] = '0;

        if (w_xfer) last_d = w_gnt1;
        if (w_gnt1) begin
            alu_op_d = bus.req1_opcode;
            alu_a_d  = bus.req1_a;
            alu_b_d  = bus.req1_b;
        end else if (w_gnt0) begin
            alu_op_d = bus.req0_opcode;
            alu_a_d  = bus.req0_a;
            alu_b_d  = bus.req0_b;
        end

        pv_d[0]   = w_xfer;
        pid_d[0]  = w_gnt1;
        pn_d[0]   = w_xfer & (alu_op_d == c_OP_NORM);
        ptag_d[0] = w_gnt1 ? bus.req1_tag : bus.req0_tag;
        for (int i = 1; i < LAT; i++) begin
            pv_d[i]   = pv_q[i-1];
            pid_d[i]  = pid_q[i-1];
            pn_d[i]   = pn_q[i-1];
            ptag_d[i] = ptag_q[i-1];
        end
        if (clr) pv_d = '0;

        rsp0_d    = pv_q[LAT-1] & ~pid_q[LAT-1] & ~clr;
        rsp1_d    = pv_q[LAT-1] &  pid_q[LAT-1] & ~clr;
        rspn_d    = pv_q[LAT-1] &  pn_q[LAT-1]  & ~clr;
        rsp_tag_d = ptag_q[LAT-1];
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= 1'b1;
            alu_en_q  <= 1'b0;
            alu_op_q  <= c_OP_RST;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            pv_q      <= '0;
            pid_q     <= '0;
            pn_q      <= '0;
            for (int i = 0; i < LAT; i++) ptag_q[i] <= '0;
            rsp0_q    <= 1'b0;
            rsp1_q    <= 1'b0;
            rspn_q    <= 1'b0;
            rsp_tag_q <= '0;
        end else begin
            last_q    <= last_d;
            alu_en_q  <= alu_en_d;
            alu_op_q  <= alu_op_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            pv_q      <= pv_d;
            pid_q     <= pid_d;
            pn_q      <= pn_d;
            for (int i = 0; i < LAT; i++) ptag_q[i] <= ptag_d[i];
            rsp0_q    <= rsp0_d;
            rsp1_q    <= rsp1_d;
            rspn_q    <= rspn_d;
            rsp_tag_q <= rsp_tag_d;
        end
    end

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.alu_en     = alu_en_q;
    assign bus.alu_opcode = alu_op_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_data   = bus.alu_y;
    assign bus.busy       = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_fpalu_issue_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_fpalu_issue_arb
// Vector table, directed corner sequences and random traffic vs a queue model.
// Rev    : 1.0
// ============================================================================
module tb_fpalu_issue_arb;
    localparam int LAT = 5;
    localparam int TW  = 4;

    logic clk2  = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    always #5 clk2 = ~clk2;

    fpalu_issue_arb_if #(.TW(TW)) bus ();
    fpalu_issue_arb #(.LAT(LAT), .TW(TW)) dut (
        .clk2 (clk2),
        .rst_n(rst_n),
        .clr  (clr),
        .bus  (bus)
    );

    typedef struct {
        int            iss;
        bit            id;
        logic [TW-1:0] tag;
        logic [1:0]    op;
    } ent_t;

    typedef struct {
        bit         v0;
        logic [1:0] op0;
        bit         v1;
        logic [1:0] op1;
        bit         c;
        bit         e0;
        bit         e1;
    } vec_t;

    ent_t        q[$];
    int          cyc;
    bit          m_last;
    logic [1:0]  m_op;
    logic [28:0] m_a, m_b;
    int          total, bad;

    bit          obs_rdy0, obs_rdy1, obs_r0, obs_r1;
    logic [TW-1:0] obs_tag;
    logic [28:0] obs_a;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit m_busy();
        foreach (q[i]) if (q[i].iss + LAT + 1 >= cyc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_nbusy();
        foreach (q[i]) if (q[i].op == 2'b00 && q[i].iss + LAT + 1 >= cyc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_last = 1'b1;
        m_op   = 2'b11;
        m_a    = '0;
        m_b    = '0;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_alu_en"},  64'(bus.alu_en),     64'(0));
        chk({nm, "_alu_op"},  64'(bus.alu_opcode), 64'(3));
        chk({nm, "_alu_a"},   64'(bus.alu_a),      64'(0));
        chk({nm, "_alu_b"},   64'(bus.alu_b),      64'(0));
        chk({nm, "_rsp0"},    64'(bus.rsp0_valid), 64'(0));
        chk({nm, "_rsp1"},    64'(bus.rsp1_valid), 64'(0));
        chk({nm, "_rsp_tag"}, 64'(bus.rsp_tag),    64'(0));
        chk({nm, "_busy"},    64'(bus.busy),       64'(0));
    endtask

    // Compare one cycle against the model, then record what the model accepts.
    task automatic check_and_commit(output bit g0, output bit g1);
        bit e0, e1, en, r0, r1;
        logic [TW-1:0] et;
        e0 = bus.req0_valid && !clr && ((bus.req0_opcode == 2'b00) ? !m_busy() : !m_nbusy());
        e1 = bus.req1_valid && !clr && ((bus.req1_opcode == 2'b00) ? !m_busy() : !m_nbusy());
        g0 = e0 && (!e1 || m_last);
        g1 = e1 && (!e0 || !m_last);
        en = 1'b0; r0 = 1'b0; r1 = 1'b0; et = '0;
        foreach (q[i]) begin
            if (q[i].iss == cyc - 1) en = 1'b1;
            if (q[i].iss + LAT + 1 == cyc) begin
                if (q[i].id) r1 = 1'b1; else r0 = 1'b0 | 1'b1;
                et = q[i].tag;
            end
        end
        obs_rdy0 = bus.req0_ready; obs_rdy1 = bus.req1_ready;
        obs_r0 = bus.rsp0_valid;   obs_r1 = bus.rsp1_valid;
        obs_tag = bus.rsp_tag;     obs_a = bus.alu_a;
        chk("req0_ready", 64'(bus.req0_ready), 64'(g0));
        chk("req1_ready", 64'(bus.req1_ready), 64'(g1));
        chk("busy",       64'(bus.busy),       64'(m_busy()));
        chk("alu_en",     64'(bus.alu_en),     64'(en));
        chk("alu_opcode", 64'(bus.alu_opcode), 64'(m_op));
        chk("alu_a",      64'(bus.alu_a),      64'(m_a));
        chk("alu_b",      64'(bus.alu_b),      64'(m_b));
        chk("rsp0_valid", 64'(bus.rsp0_valid), 64'(r0));
        chk("rsp1_valid", 64'(bus.rsp1_valid), 64'(r1));
        chk("rsp_data",   64'(bus.rsp_data),   64'(bus.alu_y));
        if (r0 || r1) chk("rsp_tag", 64'(bus.rsp_tag), 64'(et));
        if (clr) q.delete();
        if (g0 || g1) begin
            q.push_back('{iss: cyc, id: g1,
                          tag: g1 ? bus.req1_tag : bus.req0_tag,
                          op:  g1 ? bus.req1_opcode : bus.req0_opcode});
            m_op   = g1 ? bus.req1_opcode : bus.req0_opcode;
            m_a    = g1 ? bus.req1_a : bus.req0_a;
            m_b    = g1 ? bus.req1_b : bus.req0_b;
            m_last = g1;
        end
        while (q.size() > 0 && q[0].iss + LAT + 1 <= cyc) void'(q.pop_front());
    endtask

    task automatic tick(output bit g0, output bit g1);
        @(negedge clk2);
        check_and_commit(g0, g1);
        @(posedge clk2);
        #1;
        cyc++;
        bus.alu_y = 29'($urandom);
    endtask

    task automatic idle(input int n);
        bit g0, g1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        clr = 1'b0;
        for (int i = 0; i < n; i++) tick(g0, g1);
    endtask

    task automatic new_req0(input logic [1:0] op);
        bus.req0_valid = 1'b1; bus.req0_opcode = op;
        bus.req0_a = 29'($urandom); bus.req0_b = 29'($urandom); bus.req0_tag = TW'($urandom);
    endtask

    task automatic new_req1(input logic [1:0] op);
        bus.req1_valid = 1'b1; bus.req1_opcode = op;
        bus.req1_a = 29'($urandom); bus.req1_b = 29'($urandom); bus.req1_tag = TW'($urandom);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [16];
        bit   g0, g1;
        int   n, cnt;
        logic [28:0] held_a;

        total = 0; bad = 0; cyc = 0;
        model_reset();
        bus.req0_valid = 0; bus.req0_opcode = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_tag = 0;
        bus.req1_valid = 0; bus.req1_opcode = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_tag = 0;
        bus.alu_y = 0;

        // {v0, op0, v1, op1, clr, ready0, ready1}, starting idle with req0 favoured
        tbl[0]  = '{1, 2'b10, 1, 2'b01, 0, 1, 0};
        tbl[1]  = '{1, 2'b10, 1, 2'b01, 0, 0, 1};
        tbl[2]  = '{1, 2'b10, 1, 2'b01, 0, 1, 0};
        tbl[3]  = '{0, 2'b10, 1, 2'b01, 0, 0, 1};
        tbl[4]  = '{0, 2'b10, 1, 2'b00, 0, 0, 0};
        tbl[5]  = '{1, 2'b10, 1, 2'b00, 0, 1, 0};
        tbl[6]  = '{1, 2'b01, 1, 2'b00, 1, 0, 0};
        tbl[7]  = '{0, 2'b01, 1, 2'b00, 0, 0, 1};
        for (int r = 8; r < 14; r++) tbl[r] = '{1, 2'b10, 0, 2'b01, 0, 0, 0};
        tbl[14] = '{1, 2'b10, 1, 2'b01, 0, 1, 0};
        tbl[15] = '{0, 2'b10, 1, 2'b01, 0, 0, 1};

        repeat (3) @(posedge clk2);
        @(negedge clk2);
        chk_reset("por");
        rst_n = 1'b1;
        @(posedge clk2);
        #1;

        bus.req0_a = 29'h0123456; bus.req0_b = 29'h0654321; bus.req0_tag = 4'h5;
        bus.req1_a = 29'h1FEDCBA; bus.req1_b = 29'h0ABCDEF; bus.req1_tag = 4'hA;
        for (int r = 0; r < 16; r++) begin
            bus.req0_valid = tbl[r].v0; bus.req0_opcode = tbl[r].op0;
            bus.req1_valid = tbl[r].v1; bus.req1_opcode = tbl[r].op1;
            clr = tbl[r].c;
            tick(g0, g1);
            chk($sformatf("tbl%0d_ready0", r), 64'(obs_rdy0), 64'(tbl[r].e0));
            chk($sformatf("tbl%0d_ready1", r), 64'(obs_rdy1), 64'(tbl[r].e1));
        end
        idle(LAT + 3);

        // Single op: response LAT+1 cycles after the handshake cycle
        new_req0(2'b10); bus.req0_tag = 4'd3;
        tick(g0, g1);
        chk("single_accept", 64'(g0), 64'(1));
        bus.req0_valid = 1'b0;
        n = 0;
        do begin tick(g0, g1); n++; end while (!obs_r0 && n < 20);
        chk("single_latency", 64'(n), 64'(LAT + 1));
        chk("single_tag", 64'(obs_tag), 64'(3));
        idle(3);

        // Contention: both valid continuously
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || g0) new_req0(2'b01);
            if (i == 0 || g1) new_req1(2'b10);
            tick(g0, g1);
            cnt += int'(g1);
        end
        chk("contention_req1_grants", 64'(cnt), 64'(4));
        idle(LAT + 3);

        // Normalize behind 3 in-flight ops, with the requester held stalled
        for (int i = 0; i < 3; i++) begin new_req0(2'b01); tick(g0, g1); end
        bus.req0_valid = 1'b0;
        new_req1(2'b00);
        held_a = bus.req1_a;
        n = 0;
        do begin tick(g0, g1); n++; end while (!g1 && n < 30);
        chk("norm_wait", 64'(n), 64'(LAT + 2));
        bus.req1_valid = 1'b0;
        new_req0(2'b10);
        n = 0; cnt = 0;
        do begin
            tick(g0, g1); n++;
            if (n == 1) chk("bp_operand_a", 64'(obs_a), 64'(held_a));
            cnt += int'(obs_r1);
        end while (!g0 && n < 30);
        chk("norm_stall", 64'(n - 1), 64'(LAT + 1));
        chk("bp_one_rsp", 64'(cnt), 64'(1));
        idle(LAT + 3);

        // Flush two cycles after issuing four ops
        for (int i = 0; i < 4; i++) begin new_req0(2'b01); tick(g0, g1); end
        idle(1);
        clr = 1'b1;
        tick(g0, g1);
        clr = 1'b0;
        cnt = 0;
        for (int i = 0; i < LAT + 3; i++) begin tick(g0, g1); cnt += int'(obs_r0) + int'(obs_r1); end
        chk("flush_no_rsp", 64'(cnt), 64'(0));
        new_req0(2'b11); bus.req0_tag = 4'd7;
        tick(g0, g1);
        bus.req0_valid = 1'b0;
        n = 0;
        do begin tick(g0, g1); n++; end while (!obs_r0 && n < 20);
        chk("flush_after_latency", 64'(n), 64'(LAT + 1));
        idle(3);

        // Asynchronous reset with five ops in flight
        for (int i = 0; i < 5; i++) begin new_req0(2'b01); tick(g0, g1); end
        bus.req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        model_reset();
        @(posedge clk2);
        @(negedge clk2);
        chk_reset("mid_rst_hold");
        rst_n = 1'b1;
        @(posedge clk2);
        #1;
        cyc++;
        cnt = 0;
        for (int i = 0; i < LAT + 3; i++) begin tick(g0, g1); cnt += int'(obs_r0) + int'(obs_r1); end
        chk("rst_no_stale_rsp", 64'(cnt), 64'(0));
        new_req0(2'b10); new_req1(2'b10);
        tick(g0, g1);
        chk("rst_first_grant_req0", 64'(obs_rdy0), 64'(1));

        // Random traffic; unaccepted requests are held unchanged
        for (int i = 0; i < 1500; i++) begin
            if (!bus.req0_valid || g0) begin
                if ($urandom_range(0, 2) != 0)
                    new_req0(($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3)));
                else bus.req0_valid = 1'b0;
            end
            if (!bus.req1_valid || g1) begin
                if ($urandom_range(0, 2) != 0)
                    new_req1(($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3)));
                else bus.req1_valid = 1'b0;
            end
            clr = ($urandom_range(0, 49) == 0);
            tick(g0, g1);
        end
        idle(LAT + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
